// File: rtl/fw_ip4_scan_rx.sv
// Receive end of the IP4 scan interface: loads the DUT chain, shifts it out,
// packs the serial bits LSB first into 32-bit words and queues them for SW.
module fw_ip4_scan_rx #(
    parameter int CHAIN_MAX  = 768,
    parameter int FIFO_DEPTH = 32,
    parameter int DIV_W      = 8
) (
    input  logic             fw_clk,
    input  logic             fw_rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [9:0]       n_bits,
    input  logic             fw_scan_out,
    output logic             fw_scan_clk,
    output logic             fw_scan_load,
    output logic [31:0]      rd_data32,
    output logic [31:0]      status32
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  CHAIN_MAX_L = 10'(CHAIN_MAX);
    localparam logic [AW:0] FULL_L      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [DIV_W-1:0]   div_cnt_r, clk_div_r;
    logic [9:0]         nbits_r, bits_r, n_clamp_s;
    logic [31:0]        word_r, push_data_r;
    logic               push_r, scan_clk_r, scan_load_r;
    logic               busy_r, done_r, ovf_r;
    logic               tick_s, sample_s, accept_s, pop_s, full_s, wr_ok_s;
    logic [31:0]        mem_r [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [AW:0]        cnt_r;

    // Request clamp and shift-clock timing strobes.
    always_comb begin
        n_clamp_s = (n_bits > CHAIN_MAX_L) ? CHAIN_MAX_L : n_bits;
        tick_s    = ((state_r == ST_LOAD) || (state_r == ST_SHIFT)) && (div_cnt_r == clk_div_r);
        sample_s  = (state_r == ST_SHIFT) && tick_s && scan_clk_r;
        pop_s     = rd_en && (cnt_r != {(AW+1){1'b0}});
        full_s    = (cnt_r == FULL_L);
        wr_ok_s   = push_r && (!full_s || pop_s);
    end

    // Next-state decode; a start is only taken while no readout is in flight.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        accept_s    = 1'b1;
                        state_nxt_s = (n_clamp_s == 10'd0) ? ST_DONE : ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (tick_s && scan_clk_r) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (sample_s && ((bits_r + 10'd1) == nbits_r)) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_FLUSH: state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer state, scan pin generation and word packing.
    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= '0;
            clk_div_r   <= '0;
            nbits_r     <= 10'd0;
            bits_r      <= 10'd0;
            word_r      <= 32'd0;
            push_data_r <= 32'd0;
            push_r      <= 1'b0;
            scan_clk_r  <= 1'b0;
            scan_load_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (clear) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= '0;
            bits_r      <= 10'd0;
            word_r      <= 32'd0;
            push_r      <= 1'b0;
            scan_clk_r  <= 1'b0;
            scan_load_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_SHIFT) ||
                       (state_nxt_s == ST_FLUSH);
            push_r  <= 1'b0;
            if (accept_s) begin
                clk_div_r   <= clk_div;
                nbits_r     <= n_clamp_s;
                bits_r      <= 10'd0;
                word_r      <= 32'd0;
                div_cnt_r   <= '0;
                scan_clk_r  <= 1'b0;
                scan_load_r <= (n_clamp_s != 10'd0);
                done_r      <= 1'b0;
            end else begin
                if (state_r == ST_DONE) begin
                    done_r     <= 1'b1;
                    scan_clk_r <= 1'b0;
                end
                if (tick_s) begin
                    div_cnt_r  <= '0;
                    scan_clk_r <= ~scan_clk_r;
                    if ((state_r == ST_LOAD) && scan_clk_r) begin
                        scan_load_r <= 1'b0;
                    end
                end else if ((state_r == ST_LOAD) || (state_r == ST_SHIFT)) begin
                    div_cnt_r <= div_cnt_r + DIV_W'(1);
                end
                if (sample_s) begin
                    bits_r <= bits_r + 10'd1;
                    if (bits_r[4:0] == 5'd31) begin
                        push_r      <= 1'b1;
                        push_data_r <= {fw_scan_out, word_r[30:0]};
                        word_r      <= 32'd0;
                    end else begin
                        word_r[bits_r[4:0]] <= fw_scan_out;
                    end
                end
                // Partial last word; its unsampled upper bits are still zero.
                if ((state_r == ST_FLUSH) && (bits_r[4:0] != 5'd0)) begin
                    push_r      <= 1'b1;
                    push_data_r <= word_r;
                end
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_r && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
            if (wr_ok_s && !pop_s) begin
                cnt_r <= cnt_r + (AW+1)'(1);
            end else if (!wr_ok_s && pop_s) begin
                cnt_r <= cnt_r - (AW+1)'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge fw_clk) begin
        if (wr_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end
    end

    assign fw_scan_clk  = scan_clk_r;
    assign fw_scan_load = scan_load_r;
    assign rd_data32    = (cnt_r != {(AW+1){1'b0}}) ? mem_r[rd_ptr_r] : 32'd0;
    assign status32     = {6'd0, bits_r, 2'd0, 6'(cnt_r), 5'd0, ovf_r, done_r, busy_r};

endmodule

// File: tb/tb_fw_ip4_scan_rx.sv
// Randomised bench for fw_ip4_scan_rx: a behavioural scan chain drives the DUT
// and a word-queue model predicts FIFO contents and status after each readout.
module tb_fw_ip4_scan_rx;

    logic        fw_clk = 1'b0;
    logic        fw_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  clk_div = 8'd0;
    logic [9:0]  n_bits = 10'd0;
    logic        fw_scan_out = 1'b0;
    logic        fw_scan_clk, fw_scan_load;
    logic [31:0] rd_data32, status32;

    int total = 0;
    int bad = 0;

    logic [767:0] pat = '0;
    logic [31:0]  mq[$];
    bit           m_ovf = 1'b0;
    bit           m_done = 1'b0;
    int           m_bits = 0;
    bit           settled = 1'b0;

    int     rises = 0;
    int     falls = 0;
    int     sh_idx = 0;
    longint last_rise = 0;
    longint period = 0;
    int     load_cyc = 0;
    int     busy_cyc = 0;

    fw_ip4_scan_rx dut (
        .fw_clk      (fw_clk),
        .fw_rst_n    (fw_rst_n),
        .start       (start),
        .clear       (clear),
        .rd_en       (rd_en),
        .clk_div     (clk_div),
        .n_bits      (n_bits),
        .fw_scan_out (fw_scan_out),
        .fw_scan_clk (fw_scan_clk),
        .fw_scan_load(fw_scan_load),
        .rd_data32   (rd_data32),
        .status32    (status32)
    );

    always #5 fw_clk = ~fw_clk;

    // DUT scan chain: capture on a load rise, present bit k on the k-th shift rise.
    always @(posedge fw_scan_clk) begin
        rises++;
        period    = longint'($time) - last_rise;
        last_rise = longint'($time);
        if (fw_scan_load) begin
            sh_idx = 0;
        end else begin
            fw_scan_out = (sh_idx < 768) ? pat[sh_idx] : 1'b0;
            sh_idx++;
        end
    end

    always @(negedge fw_scan_clk) falls++;

    always @(negedge fw_clk) begin
        if (fw_scan_load) load_cyc++;
        if (status32[0]) busy_cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] head_exp();
        return (mq.size() > 0) ? mq[0] : 32'd0;
    endfunction

    // Whenever the DUT is quiescent its outputs must match the model.
    always @(negedge fw_clk) begin
        if (settled && fw_rst_n) begin
            chk("head", rd_data32, head_exp());
            chk("fifo_count", 32'(status32[13:8]), 32'(mq.size()));
            chk("overflow", 32'(status32[2]), 32'(m_ovf));
            chk("done", 32'(status32[1]), 32'(m_done));
            chk("busy", 32'(status32[0]), 32'd0);
            chk("bits_captured", 32'(status32[25:16]), 32'(m_bits));
            chk("reserved", status32 & 32'hFC00_C0F8, 32'd0);
            chk("idle_pins", {30'd0, fw_scan_clk, fw_scan_load}, 32'd0);
        end
    end

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_bits = 0;
    endtask

    task automatic model_readout(input int n);
        int nc;
        nc = (n > 768) ? 768 : n;
        for (int w = 0; w * 32 < nc; w++) begin
            logic [31:0] word;
            word = pat[w*32 +: 32];
            for (int b = 0; b < 32; b++) begin
                if (w * 32 + b >= nc) word[b] = 1'b0;
            end
            if (mq.size() < 32) mq.push_back(word);
            else m_ovf = 1'b1;
        end
        m_bits = nc;
        m_done = 1'b1;
    endtask

    task automatic run_start(input int div, input int n);
        settled = 1'b0;
        @(posedge fw_clk); #1;
        clk_div = 8'(div);
        n_bits  = 10'(n);
        start   = 1'b1;
        @(posedge fw_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, output int lat);
        lat = 1;
        @(negedge fw_clk);
        chk("done_cleared_by_start", 32'(status32[1]), 32'd0);
        while (!status32[1] && lat < 20000) begin
            @(negedge fw_clk);
            lat++;
        end
        chk("done_reached", 32'(status32[1]), 32'd1);
        model_readout(n);
        settled = 1'b1;
    endtask

    task automatic run_readout(input int div, input int n, output int lat);
        run_start(div, n);
        wait_done(n, lat);
    endtask

    task automatic pop();
        @(posedge fw_clk); #1;
        rd_en = 1'b1;
        @(posedge fw_clk);
        if (mq.size() > 0) void'(mq.pop_front());
        #1 rd_en = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge fw_clk); #1;
        clear = 1'b1;
        @(posedge fw_clk);
        model_clear();
        #1 clear = 1'b0;
        settled = 1'b1;
    endtask

    task automatic wait_falls(input int target);
        for (int c = 0; c < 20000 && falls < target; c++) begin
            @(posedge fw_clk); #1;
        end
        chk("fall_wait", 32'(falls >= target), 32'd1);
    endtask

    initial begin
        int lat, r0, f0, n, npop;

        @(negedge fw_clk);
        chk("rst_status", status32, 32'd0);
        chk("rst_rdata", rd_data32, 32'd0);
        chk("rst_pins", {30'd0, fw_scan_clk, fw_scan_load}, 32'd0);
        repeat (2) @(posedge fw_clk);
        #1 fw_rst_n = 1'b1;
        model_clear();
        settled = 1'b1;

        // Single full word, fastest shift clock.
        pat[31:0] = 32'hA5A5_5A5A;
        r0 = rises;
        run_readout(0, 32, lat);
        chk("t1_rises", 32'(rises - r0), 32'd33);
        chk("t1_word", rd_data32, 32'hA5A5_5A5A);
        chk("t1_status", status32, 32'h0020_0102);

        // Partial second word is zero-padded.
        do_clear();
        pat[39:0] = 40'hFF_1234_5678;
        run_readout(0, 40, lat);
        chk("t2_word0", rd_data32, 32'h1234_5678);
        chk("t2_bits", 32'(status32[25:16]), 32'd40);
        pop();
        chk("t2_word1", rd_data32, 32'h0000_00FF);

        // Slow shift clock timing.
        load_cyc = 0;
        busy_cyc = 0;
        r0 = rises;
        run_readout(3, 8, lat);
        chk("t3_load_len", 32'(load_cyc), 32'd8);
        chk("t3_rises", 32'(rises - r0), 32'd9);
        chk("t3_period", 32'(period), 32'd80);
        chk("t3_busy_len", 32'(busy_cyc >= 70 && busy_cyc <= 74), 32'd1);

        // Zero-length request.
        do_clear();
        r0 = rises;
        load_cyc = 0;
        run_readout(0, 0, lat);
        chk("t4_latency", 32'(lat <= 2), 32'd1);
        chk("t4_rises", 32'(rises - r0), 32'd0);
        chk("t4_load", 32'(load_cyc), 32'd0);

        // Oversize request is clamped.
        do_clear();
        for (int w = 0; w < 24; w++) pat[w*32 +: 32] = $urandom();
        run_readout(0, 1000, lat);
        chk("t5_bits", 32'(status32[25:16]), 32'd768);
        chk("t5_count", 32'(status32[13:8]), 32'd24);

        // Second full chain overflows the FIFO.
        run_readout(0, 768, lat);
        chk("t6_count", 32'(status32[13:8]), 32'd32);
        chk("t6_ovf", 32'(status32[2]), 32'd1);

        // Pop coinciding with a push into a full FIFO.
        do_clear();
        run_readout(0, 768, lat);
        run_readout(0, 256, lat);
        chk("t7_full_no_ovf", 32'(status32[2]), 32'd0);
        f0 = falls;
        run_start(0, 64);
        wait_falls(f0 + 33);
        rd_en = 1'b1;
        @(posedge fw_clk);
        void'(mq.pop_front());
        #1 rd_en = 1'b0;
        @(negedge fw_clk);
        chk("t7_push_pop_ovf", 32'(status32[2]), 32'd0);
        chk("t7_push_pop_count", 32'(status32[13:8]), 32'd32);
        wait_done(64, lat);

        // Ignored start while busy, then clear mid-shift.
        f0 = falls;
        run_start(1, 200);
        wait_falls(f0 + 51);
        start  = 1'b1;
        n_bits = 10'd5;
        @(posedge fw_clk); #1;
        start = 1'b0;
        wait_falls(f0 + 101);
        chk("t8_bits_at_100", 32'(status32[25:16]), 32'd100);
        clear = 1'b1;
        @(posedge fw_clk);
        model_clear();
        #1 clear = 1'b0;
        chk("t8_pins", {30'd0, fw_scan_clk, fw_scan_load}, 32'd0);
        chk("t8_busy", 32'(status32[0]), 32'd0);
        chk("t8_count", 32'(status32[13:8]), 32'd0);
        settled = 1'b1;

        // Randomised readouts with interleaved pops and clears.
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 24; w++) pat[w*32 +: 32] = $urandom();
            n = (it == 5) ? int'($urandom_range(769, 1023)) : int'($urandom_range(1, 300));
            run_readout(int'($urandom_range(0, 2)), n, lat);
            npop = int'($urandom_range(0, 5));
            for (int p = 0; p < npop; p++) pop();
            if ($urandom_range(0, 3) == 0) do_clear();
        end

        // Asynchronous reset mid-readout.
        run_start(0, 100);
        repeat (50) @(posedge fw_clk);
        #1 fw_rst_n = 1'b0;
        #1;
        chk("t9_rst_status", status32, 32'd0);
        chk("t9_rst_rdata", rd_data32, 32'd0);
        chk("t9_rst_pins", {30'd0, fw_scan_clk, fw_scan_load}, 32'd0);
        @(posedge fw_clk); #1;
        fw_rst_n = 1'b1;
        model_clear();
        settled = 1'b1;
        repeat (4) @(posedge fw_clk);
        pop();
        repeat (2) @(posedge fw_clk);

        settled = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
